// File: rtl/struct_pair_packer.sv
// Collects two packed_struct_t beats into one output pair: part_a values side by side,
// part_b values XOR-folded into a tag. Counts delivered pairs.
module struct_pair_packer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0][3:0]  out_arr,
    output logic [1:0]       out_tag,
    output logic [CNT_W-1:0] pair_count
);

    typedef struct packed {
        logic [3:0] part_a;
        logic [1:0] part_b;
    } packed_struct_t;

    typedef enum logic [1:0] {
        StIdle,
        StHalf,
        StFull
    } state_e;

    state_e           state_q, state_d;
    logic [1:0][3:0]  arr_q, arr_d;
    logic [1:0]       tag_q, tag_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    packed_struct_t beat;
    logic           accept;

    assign beat = packed_struct_t'(in_data);

    always_comb begin
        state_d = state_q;
        arr_d   = arr_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;

        // flush blocks acceptance in every state; in FULL that is its only effect
        in_ready = !flush && (state_q != StFull || out_ready);
        accept   = in_valid && in_ready;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    arr_d[0] = beat.part_a;
                    tag_d    = beat.part_b;
                    state_d  = StHalf;
                end
            end
            StHalf: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (accept) begin
                    arr_d[1] = beat.part_a;
                    tag_d    = tag_q ^ beat.part_b;
                    state_d  = StFull;
                end
            end
            StFull: begin
                if (out_ready) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // a beat arriving with the handshake starts the next pair at once
                    if (accept) begin
                        arr_d[0] = beat.part_a;
                        tag_d    = beat.part_b;
                        state_d  = StHalf;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        valid_d = (state_d == StFull);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            arr_q   <= '0;
            tag_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            arr_q   <= arr_d;
            tag_q   <= tag_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_arr    = arr_q;
    assign out_tag    = tag_q;
    assign pair_count = cnt_q;

endmodule

// File: tb/tb_struct_pair_packer.sv
// Bench for struct_pair_packer: directed vector table, hand-written corner sequences and
// random traffic against a queue-based pairing model. Two instances (CNT_W=8 and 2).
module tb_struct_pair_packer;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic [5:0]      in_data;
    logic            flush;
    logic            out_ready;

    logic            in_ready, out_valid;
    logic [1:0][3:0] out_arr;
    logic [1:0]      out_tag;
    logic [7:0]      pair_count;

    logic            in_ready2, out_valid2;
    logic [1:0][3:0] out_arr2;
    logic [1:0]      out_tag2;
    logic [1:0]      pair_count2;

    struct_pair_packer #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_arr(out_arr), .out_tag(out_tag), .pair_count(pair_count)
    );

    struct_pair_packer #(.CNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .flush(flush), .out_valid(out_valid2), .out_ready(out_ready),
        .out_arr(out_arr2), .out_tag(out_tag2), .pair_count(pair_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: beats waiting to be paired, plus the pair currently offered.
    logic [5:0] held[$];
    logic       m_valid;
    logic [7:0] m_arr;
    logic [1:0] m_tag;
    int         m_cnt;
    logic       last_ready;

    typedef struct {
        logic       iv;
        logic [5:0] d;
        logic       fl;
        logic       ordy;
        logic       e_ready;
        logic       e_valid;
        logic [7:0] e_arr;
        logic [1:0] e_tag;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        held.delete();
        m_valid = 1'b0;
        m_arr   = '0;
        m_tag   = '0;
        m_cnt   = 0;
    endtask

    // Apply one cycle of inputs, check in_ready before the edge and registered state after.
    task automatic step(input logic iv, input logic [5:0] d, input logic fl, input logic ordy);
        logic exp_ready;
        in_valid  = iv;
        in_data   = d;
        flush     = fl;
        out_ready = ordy;
        #1;
        exp_ready  = !fl && (!m_valid || ordy);
        last_ready = in_ready;
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        check("in_ready_w", {31'd0, in_ready2}, {31'd0, exp_ready});
        if (m_valid && ordy) begin
            m_cnt++;
            m_valid = 1'b0;
        end
        if (fl) held.delete();
        if (iv && exp_ready) begin
            held.push_back(d);
            if (held.size() == 2) begin
                m_arr   = {held[1][5:2], held[0][5:2]};
                m_tag   = held[0][1:0] ^ held[1][1:0];
                m_valid = 1'b1;
                held.delete();
            end
        end
        @(posedge clk);
        #1;
        check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        check("out_valid_w", {31'd0, out_valid2}, {31'd0, m_valid});
        check("pair_count", {24'd0, pair_count}, m_cnt % 256);
        check("pair_count_w", {30'd0, pair_count2}, m_cnt % 4);
        if (m_valid) begin
            check("out_arr", {24'd0, out_arr}, {24'd0, m_arr});
            check("out_tag", {30'd0, out_tag}, {30'd0, m_tag});
        end
    endtask

    task automatic reset_now();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_arr", {24'd0, out_arr}, 32'd0);
        check("rst_out_tag", {30'd0, out_tag}, 32'd0);
        check("rst_pair_count", {24'd0, pair_count}, 32'd0);
        check("rst_pair_count_w", {30'd0, pair_count2}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int i, input logic iv, input logic [5:0] d, input logic fl,
                           input logic ordy, input logic er, input logic ev,
                           input logic [7:0] ea, input logic [1:0] et, input logic [7:0] ec);
        vecs[i].iv = iv; vecs[i].d = d; vecs[i].fl = fl; vecs[i].ordy = ordy;
        vecs[i].e_ready = er; vecs[i].e_valid = ev; vecs[i].e_arr = ea;
        vecs[i].e_tag = et; vecs[i].e_cnt = ec;
    endtask

    logic [1:0] wrap_exp[5];
    int         cnt_before;

    initial begin
        // Basic pair {3,1},{A,2}
        set_vec(0,  1, 6'h0D, 0, 1, 1, 0, 8'h00, 2'd0, 8'd0);
        set_vec(1,  1, 6'h2A, 0, 1, 1, 1, 8'hA3, 2'd3, 8'd0);
        set_vec(2,  0, 6'h00, 0, 1, 1, 0, 8'h00, 2'd0, 8'd1);
        // Backpressure: pair {2,1} held five cycles
        set_vec(3,  1, 6'h04, 0, 1, 1, 0, 8'h00, 2'd0, 8'd1);
        set_vec(4,  1, 6'h0B, 0, 0, 1, 1, 8'h21, 2'd3, 8'd1);
        for (int i = 5; i < 10; i++) set_vec(i, 1, 6'h3D, 0, 0, 0, 1, 8'h21, 2'd3, 8'd1);
        set_vec(10, 0, 6'h00, 0, 1, 1, 0, 8'h00, 2'd0, 8'd2);
        set_vec(11, 0, 6'h00, 0, 1, 1, 0, 8'h00, 2'd0, 8'd2);
        // Flush discards {5,1}; next pair {6,0},{7,3}
        set_vec(12, 1, 6'h15, 0, 1, 1, 0, 8'h00, 2'd0, 8'd2);
        set_vec(13, 0, 6'h00, 1, 1, 0, 0, 8'h00, 2'd0, 8'd2);
        set_vec(14, 1, 6'h18, 0, 1, 1, 0, 8'h00, 2'd0, 8'd2);
        set_vec(15, 1, 6'h1F, 0, 0, 1, 1, 8'h76, 2'd3, 8'd2);
        set_vec(16, 0, 6'h00, 0, 1, 1, 0, 8'h00, 2'd0, 8'd3);

        wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
        wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
        model_reset();
        #3;
        check("init_out_valid", {31'd0, out_valid}, 32'd0);
        check("init_pair_count", {24'd0, pair_count}, 32'd0);
        check("init_out_arr", {24'd0, out_arr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].iv, vecs[i].d, vecs[i].fl, vecs[i].ordy);
            check($sformatf("vec%0d_ready", i), {31'd0, last_ready}, {31'd0, vecs[i].e_ready});
            check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_valid});
            check($sformatf("vec%0d_cnt", i), {24'd0, pair_count}, {24'd0, vecs[i].e_cnt});
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d_arr", i), {24'd0, out_arr}, {24'd0, vecs[i].e_arr});
                check($sformatf("vec%0d_tag", i), {30'd0, out_tag}, {30'd0, vecs[i].e_tag});
            end
        end

        // Back-to-back: 8 beats at full rate give 4 pairs with no stall
        cnt_before = m_cnt;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 6'(i * 9 + 3), 1'b0, 1'b1);
            check("b2b_ready", {31'd0, last_ready}, 32'd1);
        end
        step(1'b0, 6'h00, 1'b0, 1'b1);
        check("b2b_pairs", {24'd0, pair_count}, (cnt_before + 4) % 256);

        // Reset while HALF, then a fresh pair
        step(1'b1, 6'h3F, 1'b0, 1'b1);
        reset_now();
        step(1'b1, 6'h09, 1'b0, 1'b0);
        check("post_rst_ready", {31'd0, last_ready}, 32'd1);
        step(1'b1, 6'h36, 1'b0, 1'b0);
        check("fresh_pair_arr", {24'd0, out_arr}, 32'h0000_00D2);
        check("fresh_pair_tag", {30'd0, out_tag}, 32'd3);

        // Reset while FULL, then a fresh pair
        reset_now();
        step(1'b1, 6'h11, 1'b0, 1'b0);
        step(1'b1, 6'h22, 1'b0, 1'b0);
        check("full_before_rst", {31'd0, out_valid}, 32'd1);
        reset_now();
        step(1'b1, 6'h2D, 1'b0, 1'b0);
        step(1'b1, 6'h06, 1'b0, 1'b0);
        check("fresh_pair2_arr", {24'd0, out_arr}, 32'h0000_001B);
        check("fresh_pair2_tag", {30'd0, out_tag}, 32'd3);

        // Wrap on the 2-bit counter
        reset_now();
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 6'(k * 5), 1'b0, 1'b0);
            step(1'b1, 6'(k * 7 + 1), 1'b0, 1'b0);
            step(1'b0, 6'h00, 1'b0, 1'b1);
            check($sformatf("wrap%0d", k), {30'd0, pair_count2}, {30'd0, wrap_exp[k]});
        end

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            step(1'($urandom_range(0, 3) != 0), 6'($urandom), 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
